// File: rtl/plac_adc_pkg.sv
// Shared types and defaults for the ADC conversion sequencer.
// The state enum and the counter-width helper are used by plac_adc_seq.
package plac_adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_e;

   localparam int DATA_W_DEF   = 13;
   localparam int PIPE_LAT_DEF = 5;

   // Launch/capture counters must hold a full burst plus the pipeline fill.
   function automatic int seq_cnt_width(input int burst_w, input int pipe_lat);
      return burst_w + $clog2(pipe_lat + 1);
   endfunction

endpackage

// File: rtl/plac_phase_gen.sv
// Two-phase stage-enable generator: free-running period counter while enabled,
// phase1 at count 0 and phase2 at count PHASE_DIV; restart forces the count to 0.
module plac_phase_gen #(
   parameter int PHASE_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_restart,
   output logic o_phase1_en,
   output logic o_phase2_en
);

   localparam int PC_W = $clog2(2 * PHASE_DIV);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(2 * PHASE_DIV - 1);
   localparam logic [PC_W-1:0] PC_HALF = PC_W'(PHASE_DIV);

   logic [PC_W-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc <= '0;
      end else if (i_restart) begin
         r_pc <= '0;
      end else if (i_en) begin
         r_pc <= (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
      end
   end

   assign o_phase1_en = i_en && (r_pc == '0);
   assign o_phase2_en = i_en && (r_pc == PC_HALF);

endmodule

// File: rtl/plac_adc_seq.sv
// Conversion sequencer: phase enables, sample launches, fill/drain tracking and result handshake.
// Define PLAC_SEQ_STATS_EN to add the smp_cnt/drop_cnt statistics outputs.
//
// state | meaning
// IDLE  | waiting for start; phase generator stopped
// RUN   | each phase1_en launches a sample until the burst or stop ends it
// DRAIN | no launches; phase pulses continue until every launched sample is captured
module plac_adc_seq
   import plac_adc_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int PHASE_DIV = 4,
   parameter int PIPE_LAT  = PIPE_LAT_DEF,
   parameter int BURST_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               stop,
   input  logic [DATA_W-1:0]  adc_data,
   output logic               phase1_en,
   output logic               phase2_en,
   output logic               sample_en,
   output logic [DATA_W-1:0]  m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               busy,
   output logic               done,
   output logic               overrun
`ifdef PLAC_SEQ_STATS_EN
   ,
   output logic [15:0]        smp_cnt,
   output logic [15:0]        drop_cnt
`endif
);

   localparam int CNT_W = seq_cnt_width(BURST_W, PIPE_LAT);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PIPE_LAT - 1);
   localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(PIPE_LAT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   seq_state_e         r_state;
   seq_state_e         w_state_nxt;
   logic [BURST_W-1:0] r_burst;
   logic               r_stop_seen;
   logic [CNT_W-1:0]   r_lau_cnt;
   logic [CNT_W-1:0]   r_cap_cnt;
   logic               r_filled;
   logic [1:0]         r_p1_dly;
   logic [DATA_W-1:0]  r_m_data;
   logic               r_m_valid;
   logic               r_overrun;

   logic               w_busy;
   logic               w_start_acc;
   logic               w_phase1;
   logic               w_phase2;
   logic               w_cont;
   logic               w_more;
   logic               w_last;
   logic               w_launch;
   logic               w_cap;
   logic               w_cap_data;
   logic [CNT_W-1:0]   w_pend;
   logic               w_drained;
   logic               w_done;

   assign w_busy      = (r_state != IDLE);
   assign w_start_acc = (r_state == IDLE) && start;

   plac_phase_gen #(
      .PHASE_DIV (PHASE_DIV)
   ) u_phase_gen (
      .clk         (clk),
      .rst         (rst),
      .i_en        (w_busy),
      .i_restart   (w_start_acc),
      .o_phase1_en (w_phase1),
      .o_phase2_en (w_phase2)
   );

   assign w_cont   = (r_burst == '0);
   assign w_more   = w_cont ? !(r_stop_seen || stop) : (r_lau_cnt < CNT_W'(r_burst));
   assign w_last   = !w_cont && (r_lau_cnt == CNT_W'(r_burst) - ONE_C);
   assign w_launch = (r_state == RUN) && w_phase1 && w_more;

   // After fill, r_cap_cnt = PIPE_LAT + data captures, so the difference is the samples in flight.
   assign w_cap      = r_p1_dly[1] && w_busy;
   assign w_pend     = r_filled ? (r_lau_cnt - r_cap_cnt + LAT_C) : r_lau_cnt;
   assign w_cap_data = w_cap && r_filled && (w_pend != '0);
   assign w_drained  = (w_pend == '0) || (w_cap_data && (w_pend == ONE_C));

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_phase1 && (w_last || !w_more)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_drained) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_burst     <= '0;
         r_stop_seen <= 1'b0;
         r_lau_cnt   <= '0;
         r_cap_cnt   <= '0;
         r_filled    <= 1'b0;
         r_p1_dly    <= '0;
      end else if (w_start_acc) begin
         r_burst     <= burst_len;
         r_stop_seen <= 1'b0;
         r_lau_cnt   <= '0;
         r_cap_cnt   <= '0;
         r_filled    <= 1'b0;
         r_p1_dly    <= '0;
      end else begin
         r_p1_dly <= {r_p1_dly[0], w_phase1};
         if ((r_state == RUN) && w_cont && stop) r_stop_seen <= 1'b1;
         if (w_launch) r_lau_cnt <= r_lau_cnt + 1'b1;
         if (w_cap && (!r_filled || w_cap_data)) r_cap_cnt <= r_cap_cnt + 1'b1;
         if (w_cap && !r_filled && (r_cap_cnt == FILL_LAST)) r_filled <= 1'b1;
      end
   end

   // A held word is never overwritten; a capture arriving behind it is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_start_acc) r_overrun <= 1'b0;
         if (w_cap_data) begin
            if (!r_m_valid || m_ready) begin
               r_m_data  <= adc_data;
               r_m_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

`ifdef PLAC_SEQ_STATS_EN
   logic [15:0] r_smp_cnt;
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (!rst || w_start_acc) begin
         r_smp_cnt  <= '0;
         r_drop_cnt <= '0;
      end else if (w_busy) begin
         if (r_m_valid && m_ready && (r_smp_cnt != 16'hFFFF)) r_smp_cnt <= r_smp_cnt + 1'b1;
         if (w_cap_data && r_m_valid && !m_ready && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign smp_cnt  = r_smp_cnt;
   assign drop_cnt = r_drop_cnt;
`endif

   assign phase1_en = w_phase1;
   assign phase2_en = w_phase2;
   assign sample_en = w_launch;
   assign m_data    = r_m_data;
   assign m_valid   = r_m_valid;
   assign busy      = w_busy;
   assign done      = w_done && rst;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_plac_adc_seq.sv
// Randomized bench for plac_adc_seq; expected timing and words come from closed-form
// run arithmetic (launch/capture cycle formulas) and a word queue.
module tb_plac_adc_seq;

   localparam int DATA_W  = 13;
   localparam int BURST_W = 8;
   localparam int PER     = 8;
   localparam int LAT     = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               stop;
   logic [BURST_W-1:0] burst_len;
   logic [DATA_W-1:0]  adc_data;
   logic               phase1_en;
   logic               phase2_en;
   logic               sample_en;
   logic [DATA_W-1:0]  m_data;
   logic               m_valid;
   logic               m_ready;
   logic               busy;
   logic               done;
   logic               overrun;
`ifdef PLAC_SEQ_STATS_EN
   logic [15:0]        smp_cnt;
   logic [15:0]        drop_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   plac_adc_seq #(
      .DATA_W    (DATA_W),
      .PHASE_DIV (4),
      .PIPE_LAT  (LAT),
      .BURST_W   (BURST_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .burst_len (burst_len),
      .stop      (stop),
      .adc_data  (adc_data),
      .phase1_en (phase1_en),
      .phase2_en (phase2_en),
      .sample_en (sample_en),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
`ifdef PLAC_SEQ_STATS_EN
      ,
      .smp_cnt   (smp_cnt),
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One run: rel is the cycle offset from the start pulse. Sample k launches at
   // rel 1+8k and is captured at rel 3+8(k+LAT); done sits on the last capture.
   task automatic do_run(input int blen, input bit cont, input bit hold_rdy, input bit noise);
      int n, ts, t_done, wcnt, ci;
      int cap0, cap1;
      bit bz, mv_exp;
      int ph;
      logic [DATA_W-1:0] q[$];
      logic [DATA_W-1:0] w0;
      logic [DATA_W-1:0] w_exp;
      ts     = $urandom_range(89, 74);
      n      = cont ? (ts - 1 + PER - 1) / PER : blen;
      t_done = 3 + PER * (n + LAT - 1);
      cap0   = 3 + PER * LAT;
      cap1   = cap0 + PER;
      wcnt   = 0;
      mv_exp = 1'b0;
      w0     = '0;
      for (int rel = 0; rel <= t_done + 2; rel++) begin
         @(negedge clk);
         start     = (rel == 0) || (noise && rel >= 1 && rel <= t_done && $urandom_range(3, 0) == 0);
         burst_len = (rel == 0) ? BURST_W'(blen) : BURST_W'($urandom);
         if (cont) stop = (rel == ts) || (noise && rel == 0);
         else      stop = noise && ($urandom_range(3, 0) == 0);
         adc_data  = DATA_W'($urandom);
         m_ready   = !hold_rdy;
         #1;
         bz = (rel >= 1) && (rel <= t_done);
         ph = rel - 1;
         check_eq("busy", busy, bz);
         check_eq("phase1_en", phase1_en, bz && (ph % PER == 0));
         check_eq("phase2_en", phase2_en, bz && (ph % PER == PER / 2));
         check_eq("sample_en", sample_en, bz && (ph % PER == 0) && (ph / PER < n));
         check_eq("done", done, rel == t_done);
         if (rel >= 1) check_eq("overrun", overrun, hold_rdy && n >= 2 && rel > cap1);
         if (!hold_rdy) begin
            check_eq("m_valid", m_valid, mv_exp);
            if (m_valid && m_ready) begin
               check_eq("word_pending", 32'(q.size() != 0), 1);
               if (q.size() != 0) begin
                  w_exp = q.pop_front();
                  check_eq("m_data", m_data, w_exp);
                  wcnt++;
               end
            end
         end else begin
            check_eq("held_valid", m_valid, rel > cap0);
            if (rel > cap0) check_eq("held_data", m_data, w0);
         end
`ifdef PLAC_SEQ_STATS_EN
         if (hold_rdy && rel == t_done + 1) begin
            check_eq("smp_cnt", smp_cnt, 0);
            check_eq("drop_cnt", drop_cnt, n - 1);
         end
`endif
         mv_exp = 1'b0;
         ci = (rel - 3) / PER - LAT;
         if (rel >= 3 && (rel - 3) % PER == 0 && ci >= 0 && ci < n) begin
            q.push_back(adc_data);
            mv_exp = 1'b1;
            if (ci == 0) w0 = adc_data;
         end
      end
      start = 1'b0;
      stop  = 1'b0;
      if (!hold_rdy) begin
         check_eq("word_count", wcnt, n);
      end else begin
         @(negedge clk);
         m_ready = 1'b1;
         @(negedge clk);
         #1;
         check_eq("held_released", m_valid, 0);
      end
   endtask

   task automatic do_rst_mid();
      int r, nse;
      r   = $urandom_range(15, 10);
      nse = 0;
      for (int rel = 0; rel <= r; rel++) begin
         @(negedge clk);
         start     = (rel == 0);
         burst_len = 8'd6;
         stop      = 1'b0;
         adc_data  = DATA_W'($urandom);
         m_ready   = 1'b1;
         if (rel == r) rst = 1'b0;
         #1;
         if (sample_en) nse++;
         if (rel == r) check_eq("rst_cycle_done", done, 0);
      end
      check_eq("rst_launches", nse, 2);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_phase1", phase1_en, 0);
      @(negedge clk);
      #1;
      check_eq("rst_busy2", busy, 0);
      check_eq("rst_done2", done, 0);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b1;
      stop      = 1'b0;
      burst_len = 8'd3;
      adc_data  = '0;
      m_ready   = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         check_eq("reset_busy", busy, 0);
         check_eq("reset_phase1", phase1_en, 0);
         check_eq("reset_phase2", phase2_en, 0);
         check_eq("reset_sample", sample_en, 0);
         check_eq("reset_m_valid", m_valid, 0);
         check_eq("reset_m_data", m_data, 0);
         check_eq("reset_done", done, 0);
         check_eq("reset_overrun", overrun, 0);
      end
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      #1;
      check_eq("post_reset_busy", busy, 0);

      do_run(3, 1'b0, 1'b0, 1'b0);
      do_run(1, 1'b0, 1'b0, 1'b0);
      repeat (3) do_run($urandom_range(12, 2), 1'b0, 1'b0, 1'b0);
      do_run(0, 1'b1, 1'b0, 1'b0);
      do_run(0, 1'b1, 1'b0, 1'b1);
      do_run(4, 1'b0, 1'b1, 1'b0);
      do_run(3, 1'b0, 1'b0, 1'b1);
      do_run($urandom_range(9, 2), 1'b0, 1'b0, 1'b1);
      do_rst_mid();
      do_run(3, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the summary line");
      $fatal(1, "timeout");
   end

endmodule
